pipeline_hazard_ctrl: RTL

Hazard and sequencing controller for the 5-stage pipeline. Drives forwarding selects into the execute stage. Generates stall and flush enables for the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. Runs a request/ready handshake with data memory, holding the EX/MEM register contents (A, WD, WA3M, control bits) stable until the access completes.

---
 rtl/pipeline_hazard_ctrl_pkg.sv | 39 +++
 rtl/pipeline_hazard_ctrl_if.sv | 28 ++
 rtl/pipeline_hazard_ctrl_mem_fsm.sv | 71 +++++++
 rtl/pipeline_hazard_ctrl.sv | 100 ++++++++++
 4 files changed

// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package pipe_ctrl_pkg;

    localparam int REG_AW           = 4;
    localparam int MEM_TIMEOUT_DFLT = 15;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_sel_t;

    typedef enum logic {
        M_IDLE = 1'b0,
        M_WAIT = 1'b1
    } mem_state_t;

    // Memory-stage producer is newer than writeback, so it wins.
    function automatic fwd_sel_t fwd_select(
        input logic              use_e,
        input logic [REG_AW-1:0] ra_e,
        input logic [REG_AW-1:0] wa_m,
        input logic              we_m,
        input logic [REG_AW-1:0] wa_w,
        input logic              we_w
    );
        fwd_sel_t sel;
        sel = FWD_RF;
        if (use_e && we_m && (wa_m == ra_e)) begin
            sel = FWD_MEM;
        end else if (use_e && we_w && (wa_w == ra_e)) begin
            sel = FWD_WB;
        end else begin
            sel = FWD_RF;
        end
        return sel;
    endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Bundle of pipeline-stage status inputs and hazard/memory control outputs.
interface pipeline_hazard_ctrl_if #(parameter int AW = 4);
    logic [AW-1:0] RA1D, RA2D, WA3E, WA3M, WA3W;
    logic          useA_D, useB_D;
    logic          regWriteE, memToRegE;
    logic          regWriteM, memWriteM, memToRegM;
    logic          regWriteW, PCSrcW;
    logic          mem_ready;
    logic [1:0]    forwardAE, forwardBE;
    logic          stallF, stallD, flushD, stallE, flushE, stallM, stallW;
    logic          mem_req, mem_err;

    modport master (
        output RA1D, RA2D, WA3E, WA3M, WA3W, useA_D, useB_D,
               regWriteE, memToRegE, regWriteM, memWriteM, memToRegM,
               regWriteW, PCSrcW, mem_ready,
        input  forwardAE, forwardBE, stallF, stallD, flushD, stallE, flushE,
               stallM, stallW, mem_req, mem_err
    );

    modport slave (
        input  RA1D, RA2D, WA3E, WA3M, WA3W, useA_D, useB_D,
               regWriteE, memToRegE, regWriteM, memWriteM, memToRegM,
               regWriteW, PCSrcW, mem_ready,
        output forwardAE, forwardBE, stallF, stallD, flushD, stallE, flushE,
               stallM, stallW, mem_req, mem_err
    );
endinterface

// File: rtl/pipeline_hazard_ctrl_mem_fsm.sv
// Data-memory request/ready handshake with bounded wait and timeout pulse.
module mem_handshake_fsm
    import pipe_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_mem_op,
    input  logic i_mem_ready,
    output logic o_mem_req,
    output logic o_mem_stall,
    output logic o_mem_err
);

    localparam logic [3:0] TIMEOUT_CNT = 4'(MEM_TIMEOUT - 1);

    mem_state_t r_state, w_state_nxt;
    logic [3:0] r_wait_cnt, w_wait_cnt_nxt;
    logic       w_req, w_timeout;

    // State and wait-counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= M_IDLE;
            r_wait_cnt <= 4'd0;
        end else begin
            r_state    <= w_state_nxt;
            r_wait_cnt <= w_wait_cnt_nxt;
        end
    end

    // Next-state, request and timeout decode.
    always_comb begin
        w_state_nxt    = r_state;
        w_wait_cnt_nxt = r_wait_cnt;
        w_req          = 1'b0;
        w_timeout      = 1'b0;
        case (r_state)
            M_IDLE: begin
                w_req = i_mem_op;
                if (i_mem_op && !i_mem_ready) begin
                    w_state_nxt    = M_WAIT;
                    w_wait_cnt_nxt = 4'd0;
                end else begin
                    w_state_nxt = M_IDLE;
                end
            end
            M_WAIT: begin
                w_req          = 1'b1;
                w_timeout      = (r_wait_cnt == TIMEOUT_CNT) && !i_mem_ready;
                w_wait_cnt_nxt = (r_wait_cnt == 4'hF) ? r_wait_cnt : r_wait_cnt + 4'd1;
                if (i_mem_ready || w_timeout) begin
                    w_state_nxt = M_IDLE;
                end else begin
                    w_state_nxt = M_WAIT;
                end
            end
            default: begin
                w_state_nxt    = M_IDLE;
                w_wait_cnt_nxt = 4'd0;
            end
        endcase
    end

    // Inputs may be live during reset; keep every output quiet until release.
    assign o_mem_req   = rst_n & w_req;
    assign o_mem_stall = rst_n & w_req & ~i_mem_ready & ~w_timeout;
    assign o_mem_err   = rst_n & w_timeout;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Forwarding, load-use detection and stall/flush priority for the 5-stage pipeline.
module pipeline_hazard_ctrl
#(
    parameter int REG_AW      = pipe_ctrl_pkg::REG_AW,
    parameter int MEM_TIMEOUT = pipe_ctrl_pkg::MEM_TIMEOUT_DFLT
) (
    input  logic                 clk,
    input  logic                 rst_n,
    pipeline_hazard_ctrl_if.slave bus
);
    import pipe_ctrl_pkg::*;

    logic [REG_AW-1:0] r_ra1_e, r_ra2_e;
    logic              r_use_a_e, r_use_b_e;
    logic              w_mem_op, w_mem_stall, w_mem_req, w_mem_err, w_ld_stall;
    logic              w_stall_f, w_stall_d, w_flush_d, w_stall_e, w_flush_e;
    logic              w_stall_m, w_stall_w;
    fwd_sel_t          w_fwd_a, w_fwd_b;

    assign w_mem_op = bus.memWriteM | bus.memToRegM;

    mem_handshake_fsm #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_mem_fsm (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_mem_op    (w_mem_op),
        .i_mem_ready (bus.mem_ready),
        .o_mem_req   (w_mem_req),
        .o_mem_stall (w_mem_stall),
        .o_mem_err   (w_mem_err)
    );

    assign w_ld_stall = bus.memToRegE && bus.regWriteE &&
                        ((bus.useA_D && (bus.WA3E == bus.RA1D)) ||
                         (bus.useB_D && (bus.WA3E == bus.RA2D)));

    // Priority: memory stall, then branch flush, then load-use bubble.
    always_comb begin
        w_stall_f = 1'b0;
        w_stall_d = 1'b0;
        w_flush_d = 1'b0;
        w_stall_e = 1'b0;
        w_flush_e = 1'b0;
        w_stall_m = 1'b0;
        w_stall_w = 1'b0;
        if (!rst_n) begin
            w_flush_e = 1'b0;
        end else if (w_mem_stall) begin
            w_stall_f = 1'b1;
            w_stall_d = 1'b1;
            w_stall_e = 1'b1;
            w_stall_m = 1'b1;
            w_stall_w = 1'b1;
        end else if (bus.PCSrcW) begin
            w_flush_d = 1'b1;
            w_flush_e = 1'b1;
        end else if (w_ld_stall) begin
            w_stall_f = 1'b1;
            w_stall_d = 1'b1;
            w_flush_e = 1'b1;
        end else begin
            w_flush_e = 1'b0;
        end
    end

    // Execute-stage copies of decode source operands.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ra1_e   <= '0;
            r_ra2_e   <= '0;
            r_use_a_e <= 1'b0;
            r_use_b_e <= 1'b0;
        end else if (w_flush_e) begin
            r_ra1_e   <= '0;
            r_ra2_e   <= '0;
            r_use_a_e <= 1'b0;
            r_use_b_e <= 1'b0;
        end else if (!w_stall_e) begin
            r_ra1_e   <= bus.RA1D;
            r_ra2_e   <= bus.RA2D;
            r_use_a_e <= bus.useA_D;
            r_use_b_e <= bus.useB_D;
        end
    end

    assign w_fwd_a = fwd_select(r_use_a_e, r_ra1_e, bus.WA3M, bus.regWriteM, bus.WA3W, bus.regWriteW);
    assign w_fwd_b = fwd_select(r_use_b_e, r_ra2_e, bus.WA3M, bus.regWriteM, bus.WA3W, bus.regWriteW);

    assign bus.forwardAE = w_fwd_a;
    assign bus.forwardBE = w_fwd_b;
    assign bus.stallF    = w_stall_f;
    assign bus.stallD    = w_stall_d;
    assign bus.flushD    = w_flush_d;
    assign bus.stallE    = w_stall_e;
    assign bus.flushE    = w_flush_e;
    assign bus.stallM    = w_stall_m;
    assign bus.stallW    = w_stall_w;
    assign bus.mem_req   = w_mem_req;
    assign bus.mem_err   = w_mem_err;

endmodule
